mips_data_mem: RTL and testbench

Parametrised data memory for the MIPS pipeline's MEM stage. It replaces the fixed 32-bit, zero-latency `Mem` word array with a single-clock, handshaked memory that adds configurable width, depth and wait states, plus per-byte write enables and out-of-range error reporting. The MEM stage issues one load or store at a time and stalls until the response is returned.

---
 rtl/mips_mem_pkg.sv | 27 ++
 rtl/mips_mem_array.sv | 45 ++++
 rtl/mips_data_mem.sv | 127 ++++++++++++
 tb/tb_mips_data_mem.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS MEM-stage data memory:
// FSM state encoding, wait-state counter sizing and the byte-lane merge.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_W           = 4;

    // Merges one byte lane: the new byte wins only where its enable is set.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        if (be) begin
            return new_byte;
        end else begin
            return old_byte;
        end
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word storage with a byte-enabled write port and a registered read port.
// The storage itself is never reset; only the read register is.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic                rd_zero,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Byte-lane write; suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                mem[wr_addr][8*i +: 8] <= be_merge(mem[wr_addr][8*i +: 8],
                                                   wr_data[8*i +: 8], wr_be[i]);
            end
        end
    end

    // Registered read; rd_zero forces a clean zero for stores and errors.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data <= rd_zero ? {DATA_W{1'b0}} : mem[rd_addr];
        end
    end

endmodule

// File: rtl/mips_data_mem.sv
// Handshaked data memory for the MEM stage: one transaction in flight,
// optional wait states, byte enables and out-of-range error reporting.
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                write_r;
    logic                err_r;
    logic [ADDR_W-1:0]   addr_r;

    logic                accept_s;
    logic                err_s;
    logic                enter_resp_s;
    logic                rd_zero_s;
    logic [ADDR_W-1:0]   rd_addr_s;

    // Handshake decode and read-port steering (live request in IDLE, latched one in WAIT).
    always_comb begin
        req_ready    = (state_r == ST_IDLE);
        accept_s     = req_valid && req_ready;
        err_s        = ({1'b0, req_addr} >= DEPTH_L);
        enter_resp_s = 1'b0;
        rd_addr_s    = addr_r;
        rd_zero_s    = write_r || err_r;
        if (state_r == ST_IDLE) begin
            rd_addr_s    = req_addr;
            rd_zero_s    = req_write || err_s;
            enter_resp_s = accept_s && (WAIT_STATES == 0);
        end else if (state_r == ST_WAIT) begin
            enter_resp_s = (cnt_r == {CNT_W{1'b0}});
        end else begin
            enter_resp_s = 1'b0;
        end
    end

    // Transaction FSM with wait-state counter and registered response flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            write_r   <= 1'b0;
            err_r     <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_r <= req_write;
                        addr_r  <= req_addr;
                        err_r   <= err_s;
                        if (WAIT_STATES == 0) begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_r;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    mips_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept_s && req_write && !err_s),
        .wr_addr (req_addr),
        .wr_data (req_wdata),
        .wr_be   (req_be),
        .rd_en   (enter_resp_s),
        .rd_zero (rd_zero_s),
        .rd_addr (rd_addr_s),
        .rd_data (rsp_rdata)
    );

endmodule

// File: tb/tb_mips_data_mem.sv
// Bench for mips_data_mem: three instances (0, 3 and 2 wait states, DEPTH=1000)
// driven by directed and random transactions and checked against a word-array model.
module tb_mips_data_mem;

    localparam int DW  = 32;
    localparam int DEP = 1000;
    localparam int AW  = 10;
    localparam int N   = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset     [N];
    logic          req_valid [N];
    logic          req_ready [N];
    logic          req_write [N];
    logic [AW-1:0] req_addr  [N];
    logic [DW-1:0] req_wdata [N];
    logic [3:0]    req_be    [N];
    logic          rsp_valid [N];
    logic          rsp_ready [N];
    logic [DW-1:0] rsp_rdata [N];
    logic          rsp_err   [N];

    for (genvar g = 0; g < N; g++) begin : gen_dut
        mips_data_mem #(
            .DATA_W      (DW),
            .DEPTH       (DEP),
            .ADDR_W      (AW),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) dut (
            .clock     (clock),
            .reset     (reset[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    int          ws_of [N] = '{0, 3, 2};
    logic [31:0] model [N][1024];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference store: each enabled byte replaced, out-of-range addresses ignored.
    task automatic model_store(input int k, input int addr, input logic [31:0] d, input logic [3:0] be);
        if (addr < DEP) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[k][addr][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    // One full transaction; 'hold' keeps rsp_ready low for that many extra cycles.
    task automatic txn(input int k, input bit wr, input int addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
        int          lat;
        bit          got;
        int          busy_ready;
        logic [31:0] exp_rd;
        logic        exp_err;
        exp_err = (addr >= DEP);
        exp_rd  = (wr || exp_err) ? 32'd0 : model[k][addr];
        @(negedge clock);
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = AW'(addr);
        req_wdata[k] = wd;
        req_be[k]    = be;
        rsp_ready[k] = 1'b0;
        @(posedge clock);
        #1 req_valid[k] = 1'b0;
        if (wr) model_store(k, addr, wd, be);
        lat = 0;
        got = 1'b0;
        busy_ready = 0;
        while (!got && lat < 40) begin
            @(negedge clock);
            lat++;
            if (req_ready[k]) busy_ready++;
            if (rsp_valid[k]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL rsp_timeout observed=no_response expected=response inst=%0d", k);
        end else begin
            chk("latency", 32'(lat), 32'(ws_of[k] + 1));
            chk("req_ready_busy", 32'(busy_ready), 32'd0);
            chk("rsp_rdata", rsp_rdata[k], exp_rd);
            chk("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
            for (int h = 0; h < hold; h++) begin
                @(negedge clock);
                chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
                chk("hold_rdata", rsp_rdata[k], exp_rd);
                chk("hold_ready", 32'(req_ready[k]), 32'd0);
            end
            rsp_ready[k] = 1'b1;
            @(posedge clock);
            #1 rsp_ready[k] = 1'b0;
        end
    endtask

    initial begin
        int          nbad;
        int          addr;
        bit          wr;
        int          b2b [4];
        int          acc_cyc [4];
        int          n_acc;
        int          n_rsp;

        for (int k = 0; k < N; k++) begin
            reset[k]     = 1'b1;
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_be[k]    = '0;
            rsp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1 for (int k = 0; k < N; k++) reset[k] = 1'b0;
        @(negedge clock);
        for (int k = 0; k < N; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
        end

        // Initialise a working region of instance 0 through the store path.
        for (int a = 0; a < 64; a++) txn(0, 1'b1, a, $urandom, 4'hF, 0);

        // LW / ADDI / SW sequence
        txn(0, 1'b1, 120, 32'd85, 4'hF, 0);
        txn(0, 1'b0, 120, 32'd0, 4'h0, 0);
        txn(0, 1'b1, 121, 32'd130, 4'hF, 0);
        txn(0, 1'b0, 121, 32'd0, 4'h0, 0);
        txn(0, 1'b0, 120, 32'd0, 4'h0, 0);

        // Byte lanes, then an all-lanes-disabled store
        txn(0, 1'b1, 5, 32'h11223344, 4'hF, 0);
        txn(0, 1'b1, 5, 32'hAABBCCDD, 4'b0101, 0);
        txn(0, 1'b0, 5, 32'd0, 4'h0, 0);
        chk("byte_lane_word", rsp_rdata[0], 32'h11BB33DD);
        txn(0, 1'b1, 6, $urandom, 4'h0, 0);
        txn(0, 1'b0, 6, 32'd0, 4'h0, 0);

        // Out of range: load at DEPTH, store at the top of the address space
        txn(0, 1'b0, 1000, 32'd0, 4'h0, 0);
        txn(0, 1'b1, 1023, 32'hDEADBEEF, 4'hF, 0);
        nbad = 0;
        for (int a = 0; a < 122; a++) begin
            if (a < 64 || a >= 120) begin
                if (gen_dut[0].dut.u_array.mem[a] !== model[0][a]) nbad++;
            end
        end
        chk("array_intact", 32'(nbad), 32'd0);

        // Random mix on instance 0
        repeat (60) begin
            addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                               : int'($urandom_range(0, 63));
            wr   = 1'($urandom_range(0, 1));
            txn(0, wr, addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        // Wait states (instance 1): latency 4 and a 5-cycle hold
        for (int a = 0; a < 4; a++) txn(1, 1'b1, a, $urandom, 4'hF, 0);
        txn(1, 1'b1, 3, 32'hCAFEF00D, 4'hF, 0);
        txn(1, 1'b0, 3, 32'd0, 4'h0, 5);
        repeat (12) begin
            addr = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(0, 3));
            txn(1, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 0);
        end

        // Reset during WAIT (instance 2): store commits, response dropped
        @(negedge clock);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = AW'(9);
        req_wdata[2] = 32'd7;
        req_be[2]    = 4'hF;
        @(posedge clock);
        #1 req_valid[2] = 1'b0;
        model_store(2, 9, 32'd7, 4'hF);
        @(negedge clock);
        chk("wait_req_ready", 32'(req_ready[2]), 32'd0);
        chk("wait_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        reset[2] = 1'b1;
        @(posedge clock);
        #1 reset[2] = 1'b0;
        @(negedge clock);
        chk("mid_rst_ready", 32'(req_ready[2]), 32'd1);
        chk("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
        chk("mid_rst_rdata", rsp_rdata[2], 32'd0);
        txn(2, 1'b0, 9, 32'd0, 4'h0, 0);

        // Back-to-back loads on instance 0 with rsp_ready held high
        b2b = '{120, 121, 5, 7};
        n_acc = 0;
        n_rsp = 0;
        rsp_ready[0] = 1'b1;
        req_write[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (rsp_valid[0] && n_rsp < 4) begin
                chk("b2b_rdata", rsp_rdata[0], model[0][b2b[n_rsp]]);
                n_rsp++;
            end
            if (req_ready[0] && n_acc < 4) begin
                req_valid[0] = 1'b1;
                req_addr[0]  = AW'(b2b[n_acc]);
                acc_cyc[n_acc] = c;
                n_acc++;
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        rsp_ready[0] = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd4);
        chk("b2b_responses", 32'(n_rsp), 32'd4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
